// File: rtl/pcpi_issuer_if.sv
// Handshake bundle between the core, the PCPI issuer and a PCPI coprocessor.
// "master" is the issuer's view of the bundle and "slave" is the environment's view.
`timescale 1ns/1ps
interface pcpi_issuer_if;
    logic        issue_valid;
    logic        issue_ready;
    logic [31:0] issue_insn;
    logic [31:0] issue_rs1;
    logic [31:0] issue_rs2;
    logic        pcpi_valid;
    logic [31:0] pcpi_insn;
    logic [31:0] pcpi_rs1;
    logic [31:0] pcpi_rs2;
    logic        pcpi_ready;
    logic        pcpi_wr;
    logic [31:0] pcpi_rd;
    logic        pcpi_busy;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rd;
    logic        resp_wr;
    logic [4:0]  resp_rd_idx;
    logic        resp_trap;
    logic        spurious_ready;

    modport master (
        input  issue_valid, issue_insn, issue_rs1, issue_rs2,
               pcpi_ready, pcpi_wr, pcpi_rd, pcpi_busy, resp_ready,
        output issue_ready, pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2,
               resp_valid, resp_rd, resp_wr, resp_rd_idx, resp_trap, spurious_ready
    );

    modport slave (
        output issue_valid, issue_insn, issue_rs1, issue_rs2,
               pcpi_ready, pcpi_wr, pcpi_rd, pcpi_busy, resp_ready,
        input  issue_ready, pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2,
               resp_valid, resp_rd, resp_wr, resp_rd_idx, resp_trap, spurious_ready
    );
endinterface

// File: rtl/pcpi_issuer.sv
// Issues one instruction at a time to a PCPI coprocessor, waits for its result
// (or traps after too many idle cycles) and hands the response back to the core.
`timescale 1ns/1ps
module pcpi_issuer #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic          clk,
    input  logic          resetn,
    pcpi_issuer_if.master bus
);
    // A zero timeout still needs one counter bit.
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic        pcpi_valid_q, pcpi_valid_d;
    logic [31:0] pcpi_insn_q, pcpi_insn_d;
    logic [31:0] pcpi_rs1_q, pcpi_rs1_d;
    logic [31:0] pcpi_rs2_q, pcpi_rs2_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_rd_q, resp_rd_d;
    logic        resp_wr_q, resp_wr_d;
    logic [4:0]  resp_rd_idx_q, resp_rd_idx_d;
    logic        resp_trap_q, resp_trap_d;
    logic        spurious_q, spurious_d;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        pcpi_valid_d  = pcpi_valid_q;
        pcpi_insn_d   = pcpi_insn_q;
        pcpi_rs1_d    = pcpi_rs1_q;
        pcpi_rs2_d    = pcpi_rs2_q;
        resp_valid_d  = resp_valid_q;
        resp_rd_d     = resp_rd_q;
        resp_wr_d     = resp_wr_q;
        resp_rd_idx_d = resp_rd_idx_q;
        resp_trap_d   = resp_trap_q;
        spurious_d    = spurious_q;

        case (state_q)
            IDLE: begin
                if (bus.pcpi_ready) begin
                    spurious_d = 1'b1;
                end
                if (bus.issue_valid) begin
                    pcpi_insn_d   = bus.issue_insn;
                    pcpi_rs1_d    = bus.issue_rs1;
                    pcpi_rs2_d    = bus.issue_rs2;
                    resp_rd_idx_d = bus.issue_insn[11:7];
                    cnt_d         = CNT_LOAD;
                    pcpi_valid_d  = 1'b1;
                    state_d       = WAIT;
                end
            end
            WAIT: begin
                // A result arriving on the timeout cycle still wins over the trap.
                if (bus.pcpi_ready) begin
                    resp_rd_d    = bus.pcpi_rd;
                    resp_wr_d    = bus.pcpi_wr;
                    resp_trap_d  = 1'b0;
                    pcpi_valid_d = 1'b0;
                    resp_valid_d = 1'b1;
                    state_d      = RESP;
                end else if (bus.pcpi_busy) begin
                    cnt_d = CNT_LOAD;
                end else if (cnt_q == '0) begin
                    resp_rd_d    = '0;
                    resp_wr_d    = 1'b0;
                    resp_trap_d  = 1'b1;
                    pcpi_valid_d = 1'b0;
                    resp_valid_d = 1'b1;
                    state_d      = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                if (bus.pcpi_ready) begin
                    spurious_d = 1'b1;
                end
                if (bus.resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (resetn) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            pcpi_valid_q  <= 1'b0;
            pcpi_insn_q   <= '0;
            pcpi_rs1_q    <= '0;
            pcpi_rs2_q    <= '0;
            resp_valid_q  <= 1'b0;
            resp_rd_q     <= '0;
            resp_wr_q     <= 1'b0;
            resp_rd_idx_q <= '0;
            resp_trap_q   <= 1'b0;
            spurious_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            pcpi_valid_q  <= pcpi_valid_d;
            pcpi_insn_q   <= pcpi_insn_d;
            pcpi_rs1_q    <= pcpi_rs1_d;
            pcpi_rs2_q    <= pcpi_rs2_d;
            resp_valid_q  <= resp_valid_d;
            resp_rd_q     <= resp_rd_d;
            resp_wr_q     <= resp_wr_d;
            resp_rd_idx_q <= resp_rd_idx_d;
            resp_trap_q   <= resp_trap_d;
            spurious_q    <= spurious_d;
        end
    end

    assign bus.issue_ready    = (state_q == IDLE);
    assign bus.pcpi_valid     = pcpi_valid_q;
    assign bus.pcpi_insn      = pcpi_insn_q;
    assign bus.pcpi_rs1       = pcpi_rs1_q;
    assign bus.pcpi_rs2       = pcpi_rs2_q;
    assign bus.resp_valid     = resp_valid_q;
    assign bus.resp_rd        = resp_rd_q;
    assign bus.resp_wr        = resp_wr_q;
    assign bus.resp_rd_idx    = resp_rd_idx_q;
    assign bus.resp_trap      = resp_trap_q;
    assign bus.spurious_ready = spurious_q;
endmodule

// File: tb/tb_pcpi_issuer.sv
// Scoreboard bench for pcpi_issuer: a scripted coprocessor drives each transaction,
// a closed-form model predicts the response and a monitor checks what the DUT presents.
`timescale 1ns/1ps
module tb_pcpi_issuer;
    localparam int T = 16;

    typedef struct {
        logic [4:0]  idx;
        logic        trap;
        logic        wr;
        logic [31:0] rd;
        int          cyc;
    } exp_t;

    logic clk;
    logic resetn;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;
    bit   exp_spur = 0;
    exp_t sb[$];

    pcpi_issuer_if bus ();
    pcpi_issuer_if bus0 ();

    pcpi_issuer #(.TIMEOUT_CYCLES(T)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus.master)
    );

    pcpi_issuer #(.TIMEOUT_CYCLES(0)) dut0 (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus0.master)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops an expectation when a response first appears, then checks it stays stable.
    bit          mon_active = 0;
    logic [38:0] mon_held;
    always @(negedge clk) begin
        if (bus.resp_valid === 1'b1) begin
            if (!mon_active) begin
                mon_active = 1;
                mon_held = {bus.resp_rd_idx, bus.resp_trap, bus.resp_wr, bus.resp_rd};
                if (sb.size() == 0) begin
                    checkOutput("resp_unexpected", 128'(1), 128'(0));
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    checkOutput("resp_fields", 128'(mon_held), 128'({e.idx, e.trap, e.wr, e.rd}));
                    checkOutput("resp_latency", 128'(cyc), 128'(e.cyc));
                end
            end else begin
                checkOutput("resp_stable",
                            128'({bus.resp_rd_idx, bus.resp_trap, bus.resp_wr, bus.resp_rd}),
                            128'(mon_held));
            end
        end else begin
            mon_active = 0;
        end
    end

    // One transaction: idle gap g0, busy for b cycles, idle gap g, then ready (if has_ready).
    task automatic applyStimulus(input logic [31:0] insn, input logic [31:0] rs1, input logic [31:0] rs2,
                                 input int g0, input int b, input int g, input bit has_ready,
                                 input logic [31:0] rd, input bit wr, input int hold);
        exp_t e;
        int   n;
        bit   trap;
        if (g0 > T) begin
            trap = 1;
            n = T + 1;
        end else begin
            trap = !has_ready || (g > T);
            n = g0 + b + (trap ? T + 1 : g + 1);
        end
        e.idx  = insn[11:7];
        e.trap = trap;
        e.wr   = trap ? 1'b0 : wr;
        e.rd   = trap ? 32'h0 : rd;

        bus.issue_valid = 1'b1;
        bus.issue_insn  = insn;
        bus.issue_rs1   = rs1;
        bus.issue_rs2   = rs2;
        @(posedge clk); #1;
        bus.issue_valid = 1'b0;
        e.cyc = cyc + n;
        sb.push_back(e);
        checkOutput("pcpi_req", 128'({bus.pcpi_valid, bus.pcpi_insn, bus.pcpi_rs1, bus.pcpi_rs2}),
                    128'({1'b1, insn, rs1, rs2}));

        for (int k = 0; k < n; k++) begin
            bus.pcpi_busy  = 1'b0;
            bus.pcpi_ready = 1'b0;
            bus.pcpi_rd    = $urandom;
            bus.pcpi_wr    = 1'($urandom);
            if (k >= g0 && k < g0 + b) begin
                bus.pcpi_busy = 1'b1;
            end else if (has_ready && k == g0 + b + g) begin
                bus.pcpi_ready = 1'b1;
                bus.pcpi_rd    = rd;
                bus.pcpi_wr    = wr;
            end
            @(posedge clk); #1;
        end
        bus.pcpi_busy  = 1'b0;
        bus.pcpi_ready = 1'b0;
        checkOutput("pcpi_drop", 128'({bus.pcpi_valid, bus.issue_ready}), 128'(0));

        for (int j = 0; j < hold; j++) begin
            bus.resp_ready  = 1'b0;
            bus.issue_valid = 1'b1;
            bus.issue_insn  = $urandom;
            if ($urandom_range(0, 2) == 0) begin
                bus.pcpi_ready = 1'b1;
                exp_spur = 1;
            end
            @(posedge clk); #1;
            bus.pcpi_ready = 1'b0;
            checkOutput("resp_hold", 128'({bus.issue_ready, bus.pcpi_valid, bus.resp_valid, bus.pcpi_insn}),
                        128'({1'b0, 1'b0, 1'b1, insn}));
        end
        bus.issue_valid = 1'b0;
        bus.resp_ready  = 1'b1;
        @(posedge clk); #1;
        bus.resp_ready = 1'b0;
        checkOutput("resp_done",
                    128'({bus.issue_ready, bus.resp_valid, bus.pcpi_valid, bus.spurious_ready}),
                    128'({1'b1, 1'b0, 1'b0, exp_spur}));
    endtask

    task automatic runResetAbort();
        bus.issue_valid = 1'b1;
        bus.issue_insn  = 32'h02A5C733;
        @(posedge clk); #1;
        bus.issue_valid = 1'b0;
        bus.pcpi_busy   = 1'b1;
        @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;
        resetn = 1'b0;
        bus.pcpi_busy = 1'b0;
        exp_spur = 0;
        checkOutput("abort_state",
                    128'({bus.pcpi_valid, bus.resp_valid, bus.issue_ready, bus.spurious_ready, bus.pcpi_insn}),
                    128'({1'b0, 1'b0, 1'b1, 1'b0, 32'h0}));
        bus.pcpi_ready = 1'b1;
        bus.pcpi_rd    = 32'hDEADBEEF;
        @(posedge clk); #1;
        bus.pcpi_ready = 1'b0;
        exp_spur = 1;
        checkOutput("stray_ready", 128'({bus.pcpi_valid, bus.resp_valid, bus.spurious_ready}),
                    128'({1'b0, 1'b0, 1'b1}));
        repeat (3) @(posedge clk);
        #1;
        checkOutput("no_resp_after_abort", 128'(bus.resp_valid), 128'(0));
    endtask

    // Zero timeout: the very first idle WAIT cycle traps unless ready arrives then.
    task automatic checkZeroTimeout(input bit has_ready);
        logic [31:0] rd;
        rd = $urandom;
        bus0.issue_valid = 1'b1;
        bus0.issue_insn  = $urandom;
        @(posedge clk); #1;
        bus0.issue_valid = 1'b0;
        bus0.pcpi_ready  = has_ready;
        bus0.pcpi_rd     = rd;
        bus0.pcpi_wr     = 1'b1;
        checkOutput("t0_req", 128'(bus0.pcpi_valid), 128'(1));
        @(posedge clk); #1;
        bus0.pcpi_ready = 1'b0;
        if (has_ready)
            checkOutput("t0_ready", 128'({bus0.resp_valid, bus0.resp_trap, bus0.resp_wr, bus0.resp_rd}),
                        128'({1'b1, 1'b0, 1'b1, rd}));
        else
            checkOutput("t0_trap", 128'({bus0.resp_valid, bus0.resp_trap, bus0.resp_wr, bus0.resp_rd}),
                        128'({1'b1, 1'b1, 1'b0, 32'h0}));
        bus0.resp_ready = 1'b1;
        @(posedge clk); #1;
        bus0.resp_ready = 1'b0;
        checkOutput("t0_idle", 128'({bus0.issue_ready, bus0.resp_valid}), 128'({1'b1, 1'b0}));
    endtask

    initial begin
        resetn = 1'b1;
        bus.issue_valid = 0; bus.issue_insn = 0; bus.issue_rs1 = 0; bus.issue_rs2 = 0;
        bus.pcpi_ready = 0; bus.pcpi_wr = 0; bus.pcpi_rd = 0; bus.pcpi_busy = 0; bus.resp_ready = 0;
        bus0.issue_valid = 0; bus0.issue_insn = 0; bus0.issue_rs1 = 0; bus0.issue_rs2 = 0;
        bus0.pcpi_ready = 0; bus0.pcpi_wr = 0; bus0.pcpi_rd = 0; bus0.pcpi_busy = 0; bus0.resp_ready = 0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_state",
                    128'({bus.issue_ready, bus.pcpi_valid, bus.resp_valid, bus.resp_wr, bus.resp_trap,
                          bus.spurious_ready, bus.resp_rd_idx, bus.resp_rd, bus.pcpi_insn, bus.pcpi_rs1}),
                    128'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0}));
        resetn = 1'b0;
        @(posedge clk); #1;

        $display("[TB] directed transactions");
        applyStimulus(32'h022080B3, 32'd6, 32'd7, 0, 2, 0, 1, 32'd42, 1, 0);
        applyStimulus(32'h02208133, 32'd1, 32'd2, 0, 0, 0, 0, 32'h0, 0, 0);
        applyStimulus(32'h0220C1B3, 32'd9, 32'd0, 0, 40, 0, 1, 32'hFFFFFFFF, 1, 1);
        applyStimulus(32'h02209233, 32'd3, 32'd4, 0, 0, T, 1, 32'h12345678, 1, 0);
        applyStimulus(32'h022092B3, 32'd3, 32'd4, 0, 0, T + 1, 1, 32'h12345678, 1, 0);
        applyStimulus(32'h02208333, 32'd5, 32'd5, T, 3, 2, 1, 32'h0BADF00D, 0, 0);
        applyStimulus(32'h022083B3, 32'd5, 32'd5, T + 1, 0, 0, 1, 32'h0BADF00D, 1, 0);
        applyStimulus(32'h02208433, 32'd8, 32'd8, 0, 1, 0, 1, 32'hCAFE0001, 1, 5);

        $display("[TB] reset abort");
        runResetAbort();

        $display("[TB] random transactions");
        for (int i = 0; i < 30; i++) begin
            int g0;
            g0 = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 20)) : int'($urandom_range(0, T));
            if ($urandom_range(0, 3) == 0) begin
                bus.pcpi_ready = 1'b1;
                exp_spur = 1;
                @(posedge clk); #1;
                bus.pcpi_ready = 1'b0;
            end
            applyStimulus($urandom, $urandom, $urandom, g0, int'($urandom_range(0, 10)),
                          int'($urandom_range(0, 20)), ($urandom_range(0, 3) != 0),
                          $urandom, 1'($urandom), int'($urandom_range(0, 3)));
        end

        $display("[TB] zero timeout");
        checkZeroTimeout(0);
        checkZeroTimeout(1);

        repeat (3) @(posedge clk);
        #1;
        checkOutput("scoreboard_drain", 128'(sb.size()), 128'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/pcpi_issuer.md
PCPI_ISSUER -- requirements
Module: pcpi_issuer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16, meaning the number of idle WAIT cycles (pcpi_valid=1, pcpi_busy=0, no pcpi_ready) allowed before a trap.
REQ-002 SHALL have ports as follows:
  clk  input  1  single clock; all state changes on its rising edge.
  resetn  input  1  reset, synchronous, active-high (1 = reset).
  issue_valid  input  1  core presents an instruction for the coprocessor.
  issue_ready  output  1  block accepts an instruction this cycle.
  issue_insn  input  32  instruction word.
  issue_rs1, issue_rs2  input  32 each  operand values.
  pcpi_valid  output  1  PCPI request valid.
  pcpi_insn, pcpi_rs1, pcpi_rs2  output  32 each  PCPI request payload.
  pcpi_ready  input  1  coprocessor result strobe.
  pcpi_wr  input  1  coprocessor requests register write.
  pcpi_rd  input  32  coprocessor result.
  pcpi_busy  input  1  coprocessor is computing.
  resp_valid  output  1  result available to the core.
  resp_ready  input  1  core consumes the result.
  resp_rd  output  32  result data.
  resp_wr  output  1  write-enable for resp_rd.
  resp_rd_idx  output  5  destination register (issue_insn[11:7]).
  resp_trap  output  1  no responder or timeout; core raises an illegal-instruction exception.
  spurious_ready  output  1  sticky flag: pcpi_ready seen outside WAIT.

Function
REQ-003 SHALL implement the FSM states IDLE, WAIT and RESP.
REQ-004 IDLE: issue_ready=1, pcpi_valid=0, resp_valid=0; issue_ready SHALL be 0 in every other state.
REQ-005 On issue_valid&&issue_ready, the block SHALL:
  latch insn, rs1, rs2 and rd_idx=insn[11:7];
  load the timeout counter with TIMEOUT_CYCLES;
  enter WAIT on the next cycle.
REQ-006 In WAIT:
  pcpi_valid SHALL be 1;
  pcpi_insn/rs1/rs2 SHALL hold the latched values, stable for the whole of WAIT;
  in IDLE and RESP these outputs SHALL hold their last values (don't-care but stable).
REQ-007 Timeout counter behaviour in WAIT:
  pcpi_busy=1: reload to TIMEOUT_CYCLES;
  otherwise: decrement by 1, saturating at 0.
REQ-008 On pcpi_ready=1 in WAIT, the block SHALL:
  capture pcpi_rd into resp_rd and pcpi_wr into resp_wr;
  clear resp_trap;
  enter RESP next cycle, with pcpi_valid=0 from that cycle.
  Only the first ready in WAIT is used.
REQ-009 If the counter is 0 and pcpi_busy=0 and pcpi_ready=0 in WAIT, the block SHALL set resp_trap=1, resp_wr=0, resp_rd=0 and enter RESP.
REQ-010 If pcpi_ready=1 and the timeout condition occur in the same cycle, ready SHALL win (no trap).
REQ-011 pcpi_wr=0 with pcpi_ready=1 SHALL give resp_wr=0, resp_trap=0, resp_rd=pcpi_rd as captured.
REQ-012 RESP: resp_valid=1 with resp_rd, resp_wr, resp_rd_idx and resp_trap held stable until resp_ready=1; on that cycle the block returns to IDLE next cycle.
REQ-013 Latency:
  issue accepted at cycle 0 gives pcpi_valid=1 at cycle 1;
  pcpi_ready at cycle N gives resp_valid=1 at N+1;
  minimum issue-to-resp latency is 2 cycles.
REQ-014 pcpi_ready in IDLE or RESP SHALL be ignored for data and SHALL set spurious_ready=1 until reset.
REQ-015 The counter SHALL be ceil(log2(TIMEOUT_CYCLES+1)) bits wide; TIMEOUT_CYCLES=0 SHALL trap on the first WAIT cycle with busy=0 and no ready.
REQ-016 No outputs SHALL be combinationally dependent on pcpi_* or resp_ready, except issue_ready (a function of state only).

Reset
REQ-017 While resetn=1 at a clock edge, the next state SHALL be:
  state=IDLE, counter=0;
  pcpi_valid=0, resp_valid=0, resp_wr=0, resp_trap=0, spurious_ready=0;
  resp_rd=0, resp_rd_idx=0, pcpi_insn/rs1/rs2=0.
REQ-018 Reset asserted in WAIT or RESP SHALL abort the transaction: pcpi_valid=0 the next cycle, with no response and no pending state retained.

Verification
REQ-019 MUL issue_insn=0x022080B3, rs1=6, rs2=7; responder busy 2 cycles then ready, wr=1, rd=42 -> resp_rd=42, resp_wr=1, resp_rd_idx=1, resp_trap=0; pcpi_valid low the cycle after ready.
REQ-020 No responder (busy=0, ready=0), TIMEOUT_CYCLES=16 -> resp_valid with resp_trap=1, resp_wr=0, resp_rd=0 after the 17th WAIT cycle.
REQ-021 DIV with pcpi_busy=1 for 40 cycles, then ready, rd=0xFFFFFFFF -> no trap, resp_rd=0xFFFFFFFF.
REQ-022 pcpi_ready asserted on the exact cycle the counter reaches 0 -> resp_trap=0, resp_rd=pcpi_rd.
REQ-023 resp_ready held 0 for 5 cycles in RESP -> resp_* stable, issue_ready=0, a new issue_valid is not accepted; then resp_ready=1 -> IDLE, issue_ready=1 on the next cycle.
REQ-024 resetn=1 for 1 cycle in mid-WAIT, then a stray pcpi_ready in IDLE -> pcpi_valid=0, no resp_valid, spurious_ready=1.
